mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width of all data ports.
REQ-003 The block SHALL have parameter LATENCY, default 1, legal range 1..4: cycles from the mem_en cycle to the cycle in which mem_rdata is valid.
REQ-004 The block SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants issued while if_req is waiting.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 if_req  in  1  instruction-fetch read request; held until if_ready.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_ready  out  1  one-cycle pulse: fetch complete.
REQ-010 if_rdata  out  DATA_W  fetched word; valid when if_ready is high, held until the next fetch completes.
REQ-011 dm_req  in  1  data-memory request; held until dm_ready.
REQ-012 dm_we  in  1  data write enable: 1 = store, 0 = load.
REQ-013 dm_addr  in  ADDR_W  data address.
REQ-014 dm_wdata  in  DATA_W  store data.
REQ-015 dm_ready  out  1  one-cycle pulse: data access complete.
REQ-016 dm_rdata  out  DATA_W  load result; held until the next load completes.
REQ-017 mem_en  out  1  shared-memory access strobe.
REQ-018 mem_we  out  1  shared-memory write enable.
REQ-019 mem_addr  out  ADDR_W  shared-memory address.
REQ-020 mem_wdata  out  DATA_W  shared-memory write data.
REQ-021 mem_rdata  in  DATA_W  shared-memory read data.
REQ-022 busy  out  1  high in every state except IDLE.
REQ-023 grant_dm  out  1  current or last owner: 1 = data port, 0 = fetch port.

Function
REQ-024 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-025 In IDLE, requests SHALL be sampled; if any request is high, the block SHALL latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, update grant_dm and go to ISSUE.
REQ-026 mem_we SHALL be 0 for fetch grants.
REQ-027 Arbitration SHALL follow these rules:
- only one request high: that request wins;
- both requests high: the data port wins, unless the starve counter equals STARVE_MAX, in which case the fetch port wins.
REQ-028 The starve counter SHALL behave as follows:
- +1 on a data grant while if_req is high;
- cleared on any fetch grant;
- cleared on a data grant while if_req is low;
- saturates at STARVE_MAX.
REQ-029 In ISSUE, mem_en SHALL be 1 for exactly one cycle.
- Write: next state is RESP.
- Read: next state is WAIT, with the latency counter loaded to LATENCY.
REQ-030 WAIT SHALL decrement the counter each cycle; on the edge ending the cycle in which mem_rdata is valid (LATENCY cycles after ISSUE), the block SHALL capture mem_rdata into if_rdata or dm_rdata per grant_dm and go to RESP.
REQ-031 In RESP, exactly one of if_ready/dm_ready (per grant_dm) SHALL be 1 for one cycle; the next state is IDLE.
REQ-032 Latency, with the request sampled in IDLE at cycle 0:
- read: ready at cycle LATENCY+2;
- write: ready at cycle 2;
- next grant: no earlier than the cycle after RESP.
REQ-033 A requester SHALL drop its req, or present a new request, in the cycle after its ready; the block SHALL treat req high in IDLE as a new request.
REQ-034 A request deasserted after being granted SHALL NOT abort the transaction; the ready pulse SHALL still occur once.
REQ-035 Request inputs SHALL be ignored outside IDLE; address/data changes after grant SHALL have no effect.
REQ-036 A store SHALL NOT modify dm_rdata or if_rdata.
REQ-037 Addresses SHALL pass through unmodified (no alignment checking).

Reset
REQ-038 Reset assertion SHALL immediately force:
- state IDLE;
- mem_en, mem_we, if_ready, dm_ready, busy, grant_dm = 0;
- mem_addr, mem_wdata, if_rdata, dm_rdata = 0;
- starve and latency counters = 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction with no ready pulse; the first request after reset release SHALL be served normally.

Verification (LATENCY=1, STARVE_MAX=2)
REQ-040 Fetch: if_req=1, if_addr=0x4, memory returns 0x20090007 -> mem_en high in cycle 1 only; if_ready in cycle 3; if_rdata=0x20090007.
REQ-041 Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x100; cycle 2: dm_ready=1; dm_rdata unchanged.
REQ-042 if_req and dm_req held high continuously (loads) -> grant order DM, DM, IF, DM, DM, IF; every ready pulse is single-cycle.
REQ-043 Reset pulsed during WAIT of a load -> all outputs read 0 immediately; no dm_ready; a subsequent fetch of 0x8 completes in 3 cycles.
REQ-044 if_req dropped during WAIT -> if_ready pulses exactly once; the block then stays in IDLE with busy=0.
REQ-045 Load dm_addr=0x20 followed by fetch -> dm_rdata keeps the load value after the fetch; grant_dm goes 1 then 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single shared memory port
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_dm
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]      LAT_INIT   = 3'(LATENCY);

    logic [1:0]        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_dm_q, grant_dm_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [2:0]        lat_q, lat_d;
    logic              pick_dm;

    // Data port has priority until the fetch port has been passed over STARVE_MAX times.
    assign pick_dm = dm_req && !(if_req && (starve_q == STARVE_LIM));

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_dm_d  = grant_dm_q;
        starve_d    = starve_q;
        lat_d       = lat_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d    = S_ISSUE;
                    mem_en_d   = 1'b1;
                    grant_dm_d = pick_dm;
                    if (pick_dm) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        starve_d   = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    state_d    = S_RESP;
                    dm_ready_d = grant_dm_q;
                    if_ready_d = !grant_dm_q;
                end else begin
                    state_d = S_WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            S_WAIT: begin
                // lat_q == 1 marks the cycle in which mem_rdata is valid.
                if (lat_q <= 3'd1) begin
                    state_d = S_RESP;
                    lat_d   = 3'd0;
                    if (grant_dm_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
            grant_dm_q  <= 1'b0;
            starve_q    <= '0;
            lat_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
            grant_dm_q  <= grant_dm_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;
    assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (LATENCY=1, STARVE_MAX=2)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, busy, grant_dm;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_dm(grant_dm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h4) ? 32'h20090007 : (32'hA5A50000 ^ a);
    endfunction

    // One-cycle read latency: data valid only in the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_fn(mem_addr);
        else                   mem_rdata <= 32'h0BADF00D;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the negedge of the IDLE cycle that samples the request; returns at the
    // negedge of the following IDLE cycle.
    task automatic xfer(input string tag, input bit exp_dm, input logic [31:0] exp_addr,
                        input bit exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
        step();
        check({tag, ".mem_en_c1"}, 32'(mem_en), 32'd1);
        check({tag, ".grant_dm"}, 32'(grant_dm), 32'(exp_dm));
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        check({tag, ".mem_we"}, 32'(mem_we), 32'(exp_we));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        if (exp_we) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        step();
        check({tag, ".mem_en_c2"}, 32'(mem_en), 32'd0);
        if (!exp_we) begin
            check({tag, ".early_ready"}, 32'(if_ready | dm_ready), 32'd0);
            step();
        end
        check({tag, ".if_ready"}, 32'(if_ready), 32'(!exp_dm));
        check({tag, ".dm_ready"}, 32'(dm_ready), 32'(exp_dm));
        check({tag, ".rdata"}, exp_dm ? dm_rdata : if_rdata, exp_rdata);
        step();
        check({tag, ".ready_off"}, 32'(if_ready | dm_ready), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit arb_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        reset = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        step();
        step();
        check("rst.mem_en", 32'(mem_en), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.readies", 32'(if_ready | dm_ready), 32'd0);
        check("rst.if_rdata", if_rdata, 32'd0);
        check("rst.dm_rdata", dm_rdata, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.grant_dm", 32'(grant_dm), 32'd0);
        reset = 1'b0;
        step();

        if_req = 1'b1; if_addr = 32'h4;
        xfer("fetch", 1'b0, 32'h4, 1'b0, 32'h0, 32'h20090007);
        if_req = 1'b0;

        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        xfer("store", 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0);
        dm_req = 1'b0;

        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            xfer($sformatf("arb%0d", i), arb_seq[i], arb_seq[i] ? 32'h80 : 32'h40, 1'b0, 32'h0,
                 arb_seq[i] ? 32'hA5A50080 : 32'hA5A50040);
        end
        if_req = 1'b0; dm_req = 1'b0;

        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst.mem_addr", mem_addr, 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.grant_dm", 32'(grant_dm), 32'd0);
        check("midrst.if_rdata", if_rdata, 32'd0);
        check("midrst.dm_rdata", dm_rdata, 32'd0);
        check("midrst.mem_en", 32'(mem_en | mem_we), 32'd0);
        dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst.no_ready", 32'(dm_ready | if_ready), 32'd0);
            check("midrst.idle", 32'(busy), 32'd0);
        end
        if_req = 1'b1; if_addr = 32'h8;
        xfer("post_rst", 1'b0, 32'h8, 1'b0, 32'h0, 32'hA5A50008);
        if_req = 1'b0;

        if_req = 1'b1; if_addr = 32'hC;
        step();
        check("drop.mem_en", 32'(mem_en), 32'd1);
        step();
        if_req = 1'b0;
        step();
        check("drop.if_ready", 32'(if_ready), 32'd1);
        check("drop.if_rdata", if_rdata, 32'hA5A5000C);
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop.once", 32'(if_ready), 32'd0);
            check("drop.idle", 32'(busy | mem_en), 32'd0);
        end

        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        xfer("load", 1'b1, 32'h20, 1'b0, 32'h0, 32'hA5A50020);
        dm_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h4;
        xfer("fetch2", 1'b0, 32'h4, 1'b0, 32'h0, 32'h20090007);
        if_req = 1'b0;
        check("keep.dm_rdata", dm_rdata, 32'hA5A50020);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h24; dm_wdata = 32'h12345678;
        xfer("store2", 1'b1, 32'h24, 1'b1, 32'h12345678, 32'hA5A50020);
        dm_req = 1'b0;
        check("keep.if_rdata", if_rdata, 32'h20090007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
